// File: rtl/rv32i_mem_pkg.sv
// Shared types for the RV32I fetch/load-store memory arbiter.
// Holds the FSM states, the access-owner encoding, the full-word byte mask and an address helper.
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/rv32i_arb_prio.sv
// Winner select between fetch and load/store, with a saturating starvation counter
// that forces fetch to win once it has lost STARVE_MAX arbitrations in a row.
module rv32i_arb_prio
    import rv32i_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic RN,
    input  logic if_req,
    input  logic ls_req,
    input  logic take,
    output logic win_ls
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));
    assign win_ls  = ls_req & ~(if_req & starved);

    // NOTE: flops are written with non-blocking (<=) so every always_ff reads pre-edge values.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            starve_cnt <= '0;
        end else if (take) begin
            if (!win_ls) begin
                starve_cnt <= '0;
            end else if (if_req && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store stages:
// one access at a time through IDLE -> ACCESS -> RESP, with a per-access timeout.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        RN,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_ls
);

    localparam int TW = $clog2(TIMEOUT);

    state_t        state, state_nxt;
    owner_t        owner;
    logic          take, win_ls, timed_out, first_cycle;
    logic [TW-1:0] timer;
    logic [31:0]   rdata_q;
    logic          err_q;

    rv32i_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk    (clk),
        .RN     (RN),
        .if_req (if_req),
        .ls_req (ls_req),
        .take   (take),
        .win_ls (win_ls)
    );

    assign timed_out   = (timer == TW'(TIMEOUT - 1));
    assign first_cycle = (timer == '0);

    always_ff @(posedge clk or posedge RN) begin
        if (RN) state <= IDLE;
        else    state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        mem_req   = 1'b0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_req = 1'b1;
                if_gnt  = first_cycle && (owner == OWN_IF);
                ls_gnt  = first_cycle && (owner == OWN_LS);
                if (mem_ready || timed_out) state_nxt = RESP;
            end
            RESP: begin
                if_rvalid = (owner == OWN_IF);
                ls_rvalid = (owner == OWN_LS);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The access is frozen at IDLE exit; requester inputs are not looked at again until the next IDLE.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            owner     <= OWN_IF;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            timer     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (take) begin
                owner     <= win_ls ? OWN_LS : OWN_IF;
                mem_we    <= win_ls & ls_we;
                mem_be    <= (win_ls && ls_we) ? ls_be : BE_WORD;
                mem_addr  <= word_align(win_ls ? ls_addr : if_addr);
                mem_wdata <= win_ls ? ls_wdata : '0;
            end
            timer <= (state == ACCESS) ? timer + 1'b1 : '0;
            if (state == ACCESS) begin
                if (mem_ready) begin
                    rdata_q <= mem_we ? '0 : mem_rdata;
                    err_q   <= 1'b0;
                end else if (timed_out) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign if_rdata = if_rvalid ? rdata_q : '0;
    assign if_err   = if_rvalid & err_q;
    assign ls_rdata = ls_rvalid ? rdata_q : '0;
    assign ls_err   = ls_rvalid & err_q;

    // Stalls are masked by reset so every output reads 0 while RN is held.
    assign stall_if = if_req & ~if_rvalid & ~RN;
    assign stall_ls = ls_req & ~ls_rvalid & ~RN;

endmodule
